// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter readout path.
// Frame: header byte, 12 little-endian payload bytes, XOR checksum byte.
// The snapshot struct packs total_cycles at the LSB so payload byte n is bits [8n+7:8n].
package perf_pkg;

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CSUM} perf_rd_state_t;

   localparam logic [7:0] PERF_HEADER        = 8'hA5;
   localparam int         PERF_PAYLOAD_BYTES = 12;
   localparam int         PERF_FRAME_BYTES   = 14;

   typedef struct packed {
      logic [31:0] branch_mispredicts;
      logic [31:0] stall_cycles;
      logic [31:0] total_cycles;
   } perf_snap_t;

   // Payload byte selection; indices past the payload read as zero.
   function automatic logic [7:0] perf_byte_sel(input perf_snap_t snap, input logic [3:0] idx);
      logic [95:0] flat;
      flat = snap;
      perf_byte_sel = 8'h00;
      for (int i = 0; i < PERF_PAYLOAD_BYTES; i++) begin
         if (idx == i[3:0]) perf_byte_sel = flat[8*i +: 8];
      end
   endfunction

endpackage

// File: rtl/perf_counter_readout_if.sv
// Byte-wide valid/ready stream carrying readout frames.
// master drives data/valid, slave drives ready.
// A byte moves on any clock edge where tx_valid and tx_ready are both high.
interface perf_counter_readout_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/perf_counter_readout.sv
// Snapshots three perf counters on start and streams a 14-byte frame (A5, 12 LE bytes, XOR).
// Latency: header valid the cycle after start; one byte per cycle when tx_ready is held high.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; starts during a frame are dropped and flagged.
module perf_counter_readout
   import perf_pkg::*;
#(
   parameter int         CNT_W  = 32,
   parameter logic [7:0] HEADER = PERF_HEADER
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_W-1:0]      total_cycles_in,
   input  logic [CNT_W-1:0]      stall_cycles_in,
   input  logic [CNT_W-1:0]      branch_mispredicts_in,
   perf_counter_readout_if.master tx,
   output logic                  busy,
   output logic                  start_dropped
);

   perf_rd_state_t state;
   perf_snap_t     snap;
   logic [3:0]     idx;
   logic [7:0]     csum;
   logic [7:0]     data_q;
   logic           valid_q;
   logic           xfer;

   assign xfer        = valid_q && tx.tx_ready;
   assign tx.tx_data  = data_q;
   assign tx.tx_valid = valid_q;
   assign busy        = (state != IDLE);

   // Frame sequencer: snapshot on start, then advance one byte per accepted transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         snap          <= '0;
         idx           <= '0;
         csum          <= '0;
         data_q        <= '0;
         valid_q       <= 1'b0;
         start_dropped <= 1'b0;
      end else begin
         // A start while any frame byte is still outstanding is never queued.
         if (start && state != IDLE) start_dropped <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  snap.total_cycles       <= total_cycles_in[31:0];
                  snap.stall_cycles       <= stall_cycles_in[31:0];
                  snap.branch_mispredicts <= branch_mispredicts_in[31:0];
                  state                   <= HDR;
                  valid_q                 <= 1'b1;
                  data_q                  <= HEADER;
               end
            end
            HDR: begin
               if (xfer) begin
                  csum   <= HEADER;
                  idx    <= 4'd0;
                  state  <= PAYLOAD;
                  data_q <= perf_byte_sel(snap, 4'd0);
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  csum <= csum ^ data_q;
                  idx  <= idx + 4'd1;
                  if (idx == 4'(PERF_PAYLOAD_BYTES - 1)) begin
                     state  <= CSUM;
                     // Checksum byte is the running XOR including the byte leaving now.
                     data_q <= csum ^ data_q;
                  end else begin
                     data_q <= perf_byte_sel(snap, idx + 4'd1);
                  end
               end
            end
            CSUM: begin
               if (xfer) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
                  data_q  <= 8'h00;
               end
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perf_counter_readout.sv
// Randomized bench for perf_counter_readout against a frame-level reference model.
// The model builds each expected frame from the counters sampled at an accepted start.
// All outputs are sampled 1 time unit after the rising edge.
module tb_perf_counter_readout;
   import perf_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] tot, stl, brm;
   logic        busy, start_dropped;

   perf_counter_readout_if bus();

   perf_counter_readout dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .total_cycles_in       (tot),
      .stall_cycles_in       (stl),
      .branch_mispredicts_in (brm),
      .tx                    (bus),
      .busy                  (busy),
      .start_dropped         (start_dropped)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];
   bit         m_busy;
   bit         m_dropped;
   int         m_sent;
   logic [7:0] last_byte;
   int         busy_cycles;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void build_frame(input logic [31:0] t, input logic [31:0] s, input logic [31:0] b);
      logic [31:0] w [3];
      logic [7:0]  x;
      logic [7:0]  by;
      w[0] = t; w[1] = s; w[2] = b;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      x = 8'hA5;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) begin
            by = 8'((w[k] >> (8 * j)) & 32'hFF);
            exp_q.push_back(by);
            x = x ^ by;
         end
      end
      exp_q.push_back(x);
   endfunction

   task automatic tick(input bit st, input bit rdy);
      bit         xfer, accept, stall;
      logic [7:0] d;
      start        = st;
      bus.tx_ready = rdy;
      xfer   = bus.tx_valid && rdy;
      stall  = bus.tx_valid && !rdy;
      d      = bus.tx_data;
      accept = st && !m_busy;
      if (st && m_busy) m_dropped = 1'b1;
      if (accept) build_frame(tot, stl, brm);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (xfer) begin
         chk("byte_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) chk("byte", d, exp_q.pop_front());
         m_sent++;
         last_byte = d;
         if (m_sent == PERF_FRAME_BYTES) m_busy = 1'b0;
      end
      if (accept) begin
         m_busy = 1'b1;
         m_sent = 0;
         chk("hdr_latency", bus.tx_data, 8'hA5);
      end
      if (stall) chk("hold_data", bus.tx_data, d);
      chk("valid", bus.tx_valid, m_busy);
      chk("busy", busy, m_busy);
      chk("dropped", start_dropped, m_dropped);
      if (busy) busy_cycles++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", bus.tx_valid, 0);
      chk("rst_busy", busy, 0);
      m_busy = 1'b0; m_dropped = 1'b0; m_sent = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk("rst_data", bus.tx_data, 0);
      chk("rst_dropped", start_dropped, 0);
      rst = 1'b0;
   endtask

   // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready with live inputs churning
   task automatic run_frame(input logic [31:0] t, input logic [31:0] s, input logic [31:0] b,
                            input int mode, input bit chg, input bit extra_start);
      int n;
      bit r;
      n = 0;
      tot = t; stl = s; brm = b;
      busy_cycles = 0;
      tick(1'b1, 1'b1);
      if (chg) begin
         tot = '1; stl = '1; brm = '1;
      end
      while (m_busy && n < 400) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = (n % 4 == 0) || (n % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (mode == 2) begin
            tot = $urandom; stl = $urandom; brm = $urandom;
         end
         tick(extra_start && (n == 3), r);
         n++;
      end
      chk("frame_done", m_busy, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0;
      tot = '0; stl = '0; brm = '0;
      bus.tx_ready = 1'b0;
      #2;
      do_reset();

      // all-zero frame, busy exactly 14 cycles
      run_frame(32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
      chk("busy_cycles", busy_cycles, 14);
      chk("csum_zero", last_byte, 8'hA5);

      // small known counters
      run_frame(32'h10, 32'h3, 32'h1, 0, 1'b0, 1'b0);
      chk("csum_b7", last_byte, 8'hB7);

      // same frame under ready toggling
      run_frame(32'h10, 32'h3, 32'h1, 1, 1'b0, 1'b0);
      chk("csum_b7_bp", last_byte, 8'hB7);

      // all-ones counters sent raw
      run_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
      chk("csum_ones", last_byte, 8'hA5);

      // live inputs change after start, plus a dropped second start
      run_frame($urandom, $urandom, $urandom, 0, 1'b1, 1'b1);
      chk("dropped_sticky", start_dropped, 1);

      // reset while payload index 5 is presented
      tot = 32'h0403_0201; stl = 32'h0807_0605; brm = 32'h0C0B_0A09;
      tick(1'b1, 1'b1);
      n = 0;
      while (m_sent < 6 && n < 50) begin
         tick(1'b0, 1'b1);
         n++;
      end
      chk("mid_reset_reached", m_sent, 6);
      chk("payload_idx5", bus.tx_data, 8'h06);
      do_reset();
      run_frame($urandom, $urandom, $urandom, 2, 1'b0, 1'b0);

      // start coincident with the checksum transfer is dropped, the next one accepted
      do_reset();
      tot = $urandom; stl = $urandom; brm = $urandom;
      tick(1'b1, 1'b1);
      for (int i = 0; i < 13; i++) tick(1'b0, 1'b1);
      chk("pre_csum_state", m_sent, 13);
      tick(1'b1, 1'b1);
      chk("csum_race_dropped", start_dropped, 1);
      tick(1'b1, 1'b1);
      chk("restart_valid", bus.tx_valid, 1);
      n = 0;
      while (m_busy && n < 50) begin
         tick(1'b0, 1'b1);
         n++;
      end
      chk("restart_done", m_busy, 0);

      // randomized frames with random backpressure, stray starts and idle gaps
      for (int f = 0; f < 20; f++) begin
         run_frame($urandom, $urandom, $urandom, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick(1'b0, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/perf_counter_readout.md
Name: perf_counter_readout

Overview:
Consumer side of the pipeline performance counters. On a start pulse it atomically snapshots the total-cycle, stall-cycle and branch-mispredict counters. It then streams them out as a fixed 14-byte frame over an 8-bit valid/ready interface, for a debug UART or trace port. The block sits beside the performance monitor and shares its clock and reset domain.

Parameters:
CNT_W, 32, width of each counter input; fixed at 32 for this frame format
HEADER, 8'hA5, frame start byte

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle request to snapshot and send one frame
total_cycles_in  input  32  live total-cycle counter
stall_cycles_in  input  32  live stall-cycle counter
branch_mispredicts_in  input  32  live branch-mispredict counter
tx_data  output  8  current frame byte
tx_valid  output  1  tx_data is valid
tx_ready  input  1  downstream accepts the byte this cycle
busy  output  1  frame in progress (state != IDLE)
start_dropped  output  1  sticky flag: a start arrived while busy

Behaviour:
- Reset (async, rst=1): state=IDLE, tx_valid=0, tx_data=0, busy=0, start_dropped=0, snapshot regs=0, byte index=0, checksum=0. Asserting rst mid-frame aborts the frame; tx_valid drops immediately and the frame is not resumed.
- States: IDLE, HDR, PAYLOAD, CSUM.
- IDLE, start=1 at a posedge:
  - all three inputs are latched on that same edge (atomic snapshot);
  - next state is HDR; tx_valid=1 and tx_data=HEADER in the following cycle (1-cycle latency from start to first valid byte).
- Handshake: a byte transfers on any posedge with tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never deasserts without a transfer, except on reset.
  - Back-to-back transfers are allowed, one byte per cycle.
- HDR: on transfer, checksum := HEADER, byte index := 0, next state PAYLOAD.
- PAYLOAD: 12 bytes, index 0..11.
  - Bytes 0-3: total_cycles, little-endian. Bytes 4-7: stall_cycles, little-endian. Bytes 8-11: branch_mispredicts, little-endian.
  - On each transfer, checksum ^= byte and index += 1.
  - After the transfer of index 11, next state is CSUM.
- CSUM: tx_data = checksum, the XOR of the header and all 12 payload bytes. On transfer, next state is IDLE and tx_valid=0 in the following cycle.
- busy is 1 in HDR, PAYLOAD and CSUM. It is combinational from state.
- start while state != IDLE:
  - the start is ignored and start_dropped is set to 1;
  - start_dropped clears only on reset;
  - this includes a start in the same cycle as the final CSUM transfer.
- Live inputs that change during a frame do not affect the frame; only the snapshot is sent.
- Counter values are sent raw with no saturation; values at 0xFFFFFFFF are sent as FF FF FF FF.
- Minimum frame time with tx_ready held high: 14 cycles of tx_valid. The earliest next start is accepted in the cycle after return to IDLE.

Decomposition:
- Shared package perf_pkg:
  - state enum type perf_rd_state_t {IDLE, HDR, PAYLOAD, CSUM};
  - localparams PERF_HEADER=8'hA5, PERF_PAYLOAD_BYTES=12, PERF_FRAME_BYTES=14.
- Single module; no sub-module is warranted. Byte selection is a mux indexed by the 4-bit byte index over a 96-bit concatenated snapshot.

Test Plan:
- Reset, then start with all counters=0 and tx_ready=1 -> bytes A5, then 00 x12, then checksum A5; busy high for exactly 14 cycles.
- Counters total=0x00000010, stall=0x00000003, mispredict=0x00000001, tx_ready=1 -> A5 10 00 00 00 03 00 00 00 01 00 00 00 B7.
- Same frame with tx_ready toggling 1,0,0,1 repeatedly -> identical byte sequence; tx_data stable during every not-ready cycle; no byte duplicated or skipped.
- Change all live inputs to 0xFFFFFFFF one cycle after start -> frame carries the pre-change snapshot. A second start mid-frame -> start_dropped=1, no second frame, flag stays 1 after return to IDLE.
- Assert rst during PAYLOAD index 5 -> tx_valid=0 and busy=0 immediately. After release, a new start produces a complete, correct 14-byte frame.
- Start in the same cycle as the CSUM transfer -> start_dropped=1. Start one cycle later -> accepted, with header valid on the next cycle.
